// File: rtl/fibo_index.sv
// Inverse Fibonacci search: finds the smallest n with F(n) >= value, one step per clock.
// The result is reported with a one-cycle finish pulse and held until the next search completes.
module fibo_index #(
   parameter int WIDTH = 20,
   parameter int IDX_W = 5,
   parameter int MAX_N = 30
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   output logic             busy,
   output logic             finish,
   output logic [IDX_W-1:0] index,
   output logic             exact,
   output logic             overflow,
   output logic [WIDTH-1:0] fib_val
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_N  = IDX_W'(MAX_N);
   localparam logic [IDX_W-1:0] OVF_IDX = IDX_W'(MAX_N + 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a;
   logic [WIDTH:0]   b;
   logic [IDX_W-1:0] n;
   logic [WIDTH-1:0] v;
   logic             hit;
   logic             at_max;

   assign hit    = (a >= v);
   assign at_max = (n == LAST_N);

   always_comb begin
      state_nxt = IDLE;
      busy      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = start ? SEARCH : IDLE;
         end
         SEARCH: begin
            busy      = 1'b1;
            state_nxt = (hit || at_max) ? DONE : SEARCH;
         end
         DONE: begin
            busy      = 1'b1;
            finish    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Search datapath; b carries one extra bit so F(MAX_N+1) never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a <= '0;
         b <= '0;
         n <= '0;
         v <= '0;
      end else if (state == IDLE && start) begin
         v <= value;
         a <= '0;
         b <= (WIDTH+1)'(1);
         n <= '0;
      end else if (state == SEARCH && !hit && !at_max) begin
         a <= b[WIDTH-1:0];
         b <= {1'b0, a} + b;
         n <= n + 1'b1;
      end
   end

   // Result registers change only on the SEARCH->DONE transition.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         index    <= '0;
         exact    <= 1'b0;
         overflow <= 1'b0;
         fib_val  <= '0;
      end else if (state == SEARCH) begin
         if (hit) begin
            index    <= n;
            fib_val  <= a;
            exact    <= (a == v);
            overflow <= 1'b0;
         end else if (at_max) begin
            index    <= OVF_IDX;
            fib_val  <= '1;
            exact    <= 1'b0;
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fibo_index.sv
// Directed bench for fibo_index: latency, results, handshake, reset and back-to-back behaviour.
module tb_fibo_index;

   logic        clk;
   logic        reset;
   logic        start;
   logic [19:0] value;
   logic        busy;
   logic        finish;
   logic [4:0]  index;
   logic        exact;
   logic        overflow;
   logic [19:0] fib_val;

   int total = 0;
   int bad   = 0;

   fibo_index #(.WIDTH(20), .IDX_W(5), .MAX_N(30)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .value    (value),
      .busy     (busy),
      .finish   (finish),
      .index    (index),
      .exact    (exact),
      .overflow (overflow),
      .fib_val  (fib_val)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Accept one request, then count edges until finish (0 means it never came).
   task automatic do_txn(input logic [19:0] val, output int lat, output int busy_cyc);
      start = 1'b1;
      value = val;
      tick();
      start    = 1'b0;
      lat      = 0;
      busy_cyc = 0;
      for (int i = 1; i <= 40; i++) begin
         if (busy) busy_cyc++;
         tick();
         if (finish) begin
            lat = i;
            busy_cyc++;
            break;
         end
      end
   endtask

   task automatic chk_result(input string tag, input int lat, input int exp_lat,
                             input logic [4:0] e_idx, input logic e_exact,
                             input logic e_ovf, input logic [19:0] e_fib);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_index"}, index, e_idx);
      chk({tag, "_exact"}, exact, e_exact);
      chk({tag, "_ovf"}, overflow, e_ovf);
      chk({tag, "_fib"}, fib_val, e_fib);
   endtask

   initial begin
      int lat;
      int bc;
      int prev;
      int nfin;

      reset = 1'b1;
      start = 1'b0;
      value = '0;
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_finish", finish, 0);
      chk("rst_index", index, 0);
      chk("rst_exact", exact, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_fib", fib_val, 0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // value 0: hit on first SEARCH cycle
      do_txn(20'd0, lat, bc);
      chk_result("v0", lat, 1, 5'd0, 1'b1, 1'b0, 20'd0);
      chk("v0_busy_cycles", bc, 2);
      tick();
      chk("v0_idle_busy", busy, 0);
      chk("v0_single_finish", finish, 0);

      // value 4 then 13 back-to-back
      do_txn(20'd4, lat, bc);
      chk_result("v4", lat, 6, 5'd5, 1'b0, 1'b0, 20'd5);
      tick();
      chk("v4_idle", busy, 0);
      do_txn(20'd13, lat, bc);
      chk_result("v13", lat, 8, 5'd7, 1'b1, 1'b0, 20'd13);
      tick();

      // largest representable and first overflowing value
      do_txn(20'd832040, lat, bc);
      chk_result("v832040", lat, 31, 5'd30, 1'b1, 1'b0, 20'd832040);
      tick();
      do_txn(20'd832041, lat, bc);
      chk_result("v832041", lat, 31, 5'd31, 1'b0, 1'b1, 20'hFFFFF);
      tick();
      chk("ovf_held_idle", overflow, 1);

      // value 1 with start/value churn while busy
      start = 1'b1;
      value = 20'd1;
      tick();
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         start = 1'b1;
         value = 20'($urandom);
         tick();
         if (finish) begin
            lat = i;
            break;
         end
      end
      start = 1'b0;
      chk_result("v1", lat, 2, 5'd1, 1'b1, 1'b0, 20'd1);
      tick();
      chk("v1_no_refinish", finish, 0);
      chk("v1_idle", busy, 0);
      tick();
      chk("v1_still_idle", busy, 0);

      // asynchronous reset mid-search at n=10
      start = 1'b1;
      value = 20'd1000;
      tick();
      start = 1'b0;
      repeat (10) tick();
      chk("pre_rst_busy", busy, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_finish", finish, 0);
      chk("mid_rst_index", index, 0);
      chk("mid_rst_exact", exact, 0);
      chk("mid_rst_ovf", overflow, 0);
      chk("mid_rst_fib", fib_val, 0);
      #1;
      reset = 1'b0;
      tick();
      chk("post_rst_idle", busy, 0);
      do_txn(20'd21, lat, bc);
      chk_result("v21", lat, 9, 5'd8, 1'b1, 1'b0, 20'd21);
      tick();

      // start held high: finish every 6 cycles
      start = 1'b1;
      value = 20'd2;
      prev  = -1;
      nfin  = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (finish) begin
            if (prev >= 0) chk("hold_period", i - prev, 6);
            prev = i;
            nfin++;
         end
      end
      start = 1'b0;
      chk("hold_count", (nfin >= 4) ? 1 : 0, 1);
      chk("hold_index", index, 3);
      chk("hold_exact", exact, 1);
      chk("hold_fib", fib_val, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
